// File: rtl/hex_event_mem_arbiter_if.sv
// hex_event_mem_arbiter_if: requester, memory write port and frame status bundle.
// master drives requests/memory readiness; slave is the arbiter.
interface hex_event_mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 640,
    parameter int ADDR_W  = 32
);
    logic                           frame_start;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_grant;
    logic [ADDR_W-1:0]              mem_addr;
    logic [DATA_W-1:0]              mem_data;
    logic                           mem_we;
    logic                           mem_ready;
    logic                           frame_busy;
    logic [15:0]                    frame_writes;
    logic                           err_timeout;
    modport master (
        output frame_start, req_valid, req_addr, req_data, mem_ready,
        input  req_grant, mem_addr, mem_data, mem_we, frame_busy, frame_writes, err_timeout
    );
    modport slave (
        input  frame_start, req_valid, req_addr, req_data, mem_ready,
        output req_grant, mem_addr, mem_data, mem_we, frame_busy, frame_writes, err_timeout
    );
endinterface

// File: rtl/hex_event_mem_arbiter.sv
// hex_event_mem_arbiter: round-robin event-writer arbiter onto one memory write port with frame drain.
// Define HEX_ARB_TIMEOUT_EN to drop transfers stalled for 256 cycles and flag err_timeout.
module hex_event_mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 640,
    parameter int ADDR_W  = 32
) (
    input  logic clk,
    input  logic reset_n,
    hex_event_mem_arbiter_if.slave b
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
    state_t        state, state_n;
    logic [IW-1:0] last, win;
    logic          found, grant, fw_clr, we, done, timeout;
    logic [15:0]   fw;
    assign we             = state != IDLE;
    assign done           = we && b.mem_ready;
    assign b.mem_we       = we;
    assign b.frame_busy   = state == DRAIN;
    assign b.frame_writes = fw;
    assign b.req_grant    = grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win) : '0;
    // search starts just after the last granted requester
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (!found && b.req_valid[(int'(last) + 1 + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = IW'((int'(last) + 1 + i) % NUM_REQ);
            end
    end
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        fw_clr  = 1'b0;
        case (state)
            IDLE:
                if (b.frame_start) fw_clr = 1'b1;
                else if (found) begin
                    grant   = 1'b1;
                    state_n = BUSY;
                end
            BUSY:
                if (done) begin
                    if (b.frame_start) begin
                        fw_clr  = 1'b1;
                        state_n = IDLE;
                    end else if (found) grant = 1'b1;
                    else state_n = IDLE;
                end else if (timeout) state_n = IDLE;
                else if (b.frame_start) state_n = DRAIN;
            DRAIN:
                if (done || timeout) begin
                    fw_clr  = 1'b1;
                    state_n = IDLE;
                end
            default: state_n = IDLE;
        endcase
        grant = grant && reset_n;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last       <= IW'(NUM_REQ - 1);
            b.mem_addr <= '0;
            b.mem_data <= '0;
            fw         <= '0;
        end else begin
            state <= state_n;
            if (grant) begin
                last       <= win;
                b.mem_addr <= b.req_addr[win];
                b.mem_data <= b.req_data[win];
            end
            fw <= fw_clr ? 16'd0 : (done && fw != 16'hFFFF) ? fw + 16'd1 : fw;
        end
    end
`ifdef HEX_ARB_TIMEOUT_EN
    logic [7:0] stall;
    logic       err;
    assign timeout       = we && !b.mem_ready && stall == 8'hFF;
    assign b.err_timeout = err;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall <= '0;
            err   <= 1'b0;
        end else begin
            stall <= (we && !b.mem_ready) ? stall + 8'd1 : 8'd0;
            err   <= err || timeout;
        end
    end
`else
    assign timeout       = 1'b0;
    assign b.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_hex_event_mem_arbiter.sv
// tb_hex_event_mem_arbiter: scenario tasks plus a completion scoreboard for hex_event_mem_arbiter.
module tb_hex_event_mem_arbiter;
    localparam int NR = 4;
    localparam int DW = 640;
    localparam int AW = 32;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [AW-1:0] q[$];
    hex_event_mem_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) b ();
    hex_event_mem_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .b(b.slave)
    );
    always #5 clk = ~clk;
    function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
        return {(DW/AW){a}};
    endfunction
    // every real completion must match the oldest expected grant
    always @(negedge clk) begin
        if (reset_n && b.mem_we && b.mem_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL completion: got addr %0h, expected no transfer", b.mem_addr);
            end else begin
                logic [AW-1:0] e;
                e = q.pop_front();
                if (b.mem_addr !== e || b.mem_data !== dat(e)) begin
                    errors++;
                    $display("FAIL completion: got addr %0h, expected %0h (data ok=%0b)", b.mem_addr, e, b.mem_data === dat(e));
                end
            end
        end
    end
    task automatic nxt;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        reset_n = 1'b0; b.req_valid = '1; b.frame_start = 1'b0; b.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (b.mem_we !== 1'b0) begin errors++; $display("FAIL reset mem_we: got %0b expected 0", b.mem_we); end
        checks++; if (b.req_grant !== 4'b0) begin errors++; $display("FAIL reset grant: got %0b expected 0", b.req_grant); end
        checks++; if (b.frame_busy !== 1'b0) begin errors++; $display("FAIL reset frame_busy: got %0b expected 0", b.frame_busy); end
        checks++; if (b.frame_writes !== 16'd0) begin errors++; $display("FAIL reset frame_writes: got %0d expected 0", b.frame_writes); end
        checks++; if (b.err_timeout !== 1'b0) begin errors++; $display("FAIL reset err_timeout: got %0b expected 0", b.err_timeout); end
        checks++; if (b.mem_addr !== '0 || b.mem_data !== '0) begin errors++; $display("FAIL reset mem_addr: got %0h expected 0", b.mem_addr); end
        nxt();
        reset_n = 1'b1; b.req_valid = '0;
        nxt();
    endtask
    task automatic test_round_robin;
        b.req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (b.req_grant !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr grant %0d: got %b expected %b", k, b.req_grant, 4'(1 << (k % 4))); end
            checks++; if (b.mem_we !== 1'(k != 0)) begin errors++; $display("FAIL rr mem_we %0d: got %0b expected %0b", k, b.mem_we, k != 0); end
            q.push_back(b.req_addr[k % 4]);
            nxt();
        end
        b.req_valid = '0;
        @(negedge clk);
        checks++; if (b.req_grant !== 4'b0 || b.mem_we !== 1'b1) begin errors++; $display("FAIL rr last: got grant %b we %0b expected 0000 1", b.req_grant, b.mem_we); end
        nxt();
        @(negedge clk);
        checks++; if (b.mem_we !== 1'b0 || b.frame_writes !== 16'd5) begin errors++; $display("FAIL rr count: got we %0b writes %0d expected 0 5", b.mem_we, b.frame_writes); end
        nxt();
    endtask
    task automatic test_stall;
        b.req_valid = 4'b0100; b.mem_ready = 1'b0;
        @(negedge clk);
        checks++; if (b.req_grant !== 4'b0100) begin errors++; $display("FAIL stall grant: got %b expected 0100", b.req_grant); end
        q.push_back(b.req_addr[2]);
        nxt();
        b.req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            b.mem_ready = (k == 3);
            @(negedge clk);
            checks++; if (b.mem_addr !== 32'h100 || b.mem_we !== 1'b1 || b.req_grant !== 4'b0) begin errors++; $display("FAIL stall hold %0d: got addr %0h we %0b grant %b expected 100 1 0000", k, b.mem_addr, b.mem_we, b.req_grant); end
            nxt();
        end
        @(negedge clk);
        checks++; if (b.mem_we !== 1'b0 || b.frame_writes !== 16'd6) begin errors++; $display("FAIL stall end: got we %0b writes %0d expected 0 6", b.mem_we, b.frame_writes); end
        nxt();
    endtask
    task automatic test_frame_drain;
        b.req_valid = 4'b0001; b.mem_ready = 1'b0;
        @(negedge clk);
        checks++; if (b.req_grant !== 4'b0001) begin errors++; $display("FAIL drain grant: got %b expected 0001", b.req_grant); end
        q.push_back(b.req_addr[0]);
        nxt();
        b.req_valid = 4'hF; b.frame_start = 1'b1;
        @(negedge clk);
        checks++; if (b.req_grant !== 4'b0) begin errors++; $display("FAIL drain start grant: got %b expected 0000", b.req_grant); end
        nxt();
        b.frame_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            b.mem_ready = (k == 1);
            @(negedge clk);
            checks++; if (b.frame_busy !== 1'b1 || b.req_grant !== 4'b0) begin errors++; $display("FAIL drain busy %0d: got busy %0b grant %b expected 1 0000", k, b.frame_busy, b.req_grant); end
            nxt();
        end
        b.req_valid = '0;
        @(negedge clk);
        checks++; if (b.frame_busy !== 1'b0 || b.frame_writes !== 16'd0 || b.mem_we !== 1'b0) begin errors++; $display("FAIL drain end: got busy %0b writes %0d we %0b expected 0 0 0", b.frame_busy, b.frame_writes, b.mem_we); end
        nxt();
    endtask
    task automatic test_reset_mid;
        b.req_valid = 4'b0001; b.mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (b.req_grant !== 4'b0001) begin errors++; $display("FAIL rstmid grant0: got %b expected 0001", b.req_grant); end
        q.push_back(b.req_addr[0]);
        nxt();
        b.req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (b.req_grant !== 4'b0100) begin errors++; $display("FAIL rstmid b2b grant: got %b expected 0100", b.req_grant); end
        nxt();
        reset_n = 1'b0; b.req_valid = 4'hF;
        @(negedge clk);
        checks++; if (b.req_grant !== 4'b0 || b.mem_we !== 1'b1) begin errors++; $display("FAIL rstmid reset cycle: got grant %b we %0b expected 0000 1", b.req_grant, b.mem_we); end
        nxt();
        reset_n = 1'b1; b.req_valid = 4'b1010;
        @(negedge clk);
        checks++; if (b.mem_we !== 1'b0 || b.frame_writes !== 16'd0) begin errors++; $display("FAIL rstmid after: got we %0b writes %0d expected 0 0", b.mem_we, b.frame_writes); end
        checks++; if (b.req_grant !== 4'b0010) begin errors++; $display("FAIL rstmid priority: got %b expected 0010", b.req_grant); end
        q.push_back(b.req_addr[1]);
        nxt();
        b.req_valid = '0;
        @(negedge clk);
        nxt();
        @(negedge clk);
        checks++; if (b.mem_we !== 1'b0 || b.frame_writes !== 16'd1) begin errors++; $display("FAIL rstmid count: got we %0b writes %0d expected 0 1", b.mem_we, b.frame_writes); end
        nxt();
    endtask
    task automatic test_frame_complete;
        int order[7] = '{2, 3, 0, 1, 2, 3, 0};
        b.req_valid = 4'hF; b.mem_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++; if (b.req_grant !== 4'(1 << order[k])) begin errors++; $display("FAIL fc grant %0d: got %b expected %b", k, b.req_grant, 4'(1 << order[k])); end
            q.push_back(b.req_addr[order[k]]);
            nxt();
        end
        b.frame_start = 1'b1;
        @(negedge clk);
        checks++; if (b.frame_writes !== 16'd7 || b.req_grant !== 4'b0) begin errors++; $display("FAIL fc edge: got writes %0d grant %b expected 7 0000", b.frame_writes, b.req_grant); end
        nxt();
        b.frame_start = 1'b0; b.req_valid = '0;
        @(negedge clk);
        checks++; if (b.frame_writes !== 16'd0 || b.mem_we !== 1'b0) begin errors++; $display("FAIL fc after: got writes %0d we %0b expected 0 0", b.frame_writes, b.mem_we); end
        nxt();
    endtask
    task automatic test_stall_hold;
        b.req_valid = 4'b0001; b.mem_ready = 1'b0;
        @(negedge clk);
        checks++; if (b.req_grant !== 4'b0001) begin errors++; $display("FAIL hold grant: got %b expected 0001", b.req_grant); end
        nxt();
        b.req_valid = '0;
`ifdef HEX_ARB_TIMEOUT_EN
        repeat (255) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (b.mem_we !== 1'b1 || b.err_timeout !== 1'b0) begin errors++; $display("FAIL timeout early: got we %0b err %0b expected 1 0", b.mem_we, b.err_timeout); end
        nxt();
        @(negedge clk);
        checks++; if (b.mem_we !== 1'b0 || b.err_timeout !== 1'b1 || b.frame_writes !== 16'd0) begin errors++; $display("FAIL timeout drop: got we %0b err %0b writes %0d expected 0 1 0", b.mem_we, b.err_timeout, b.frame_writes); end
        nxt();
`else
        repeat (299) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (b.mem_we !== 1'b1 || b.err_timeout !== 1'b0 || b.mem_addr !== b.req_addr[0]) begin errors++; $display("FAIL hold long: got we %0b err %0b addr %0h expected 1 0 %0h", b.mem_we, b.err_timeout, b.mem_addr, b.req_addr[0]); end
        nxt();
        q.push_back(b.req_addr[0]);
        b.mem_ready = 1'b1;
        @(negedge clk);
        nxt();
        @(negedge clk);
        checks++; if (b.mem_we !== 1'b0 || b.frame_writes !== 16'd1) begin errors++; $display("FAIL hold end: got we %0b writes %0d expected 0 1", b.mem_we, b.frame_writes); end
        nxt();
`endif
    endtask
    initial begin
        logic [AW-1:0] base[NR] = '{32'h1000, 32'h2000, 32'h100, 32'h4000};
        b.frame_start = 1'b0; b.req_valid = '0; b.mem_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            b.req_addr[i] = base[i];
            b.req_data[i] = dat(base[i]);
        end
        nxt();
        test_reset();
        test_round_robin();
        test_stall();
        test_frame_drain();
        test_reset_mid();
        test_frame_complete();
        test_stall_hold();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL scoreboard drain: got %0d pending expected 0", q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
